// File: rtl/pipe_ctrl.sv
// pipe_ctrl - central stall/flush controller for the five-stage core.
//
// Produces the load enables (*_Wr) and synchronous clears (*_Flush) for the
// PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It
// resolves, highest priority first: MEM-stage exceptions (possibly held
// behind a D-cache miss), back-end stalls (D-cache / MDU), load-use
// hazards, branch redirects, branch-likely annulment and fetch stalls.
//
// Ports:
//   clk, rst               core clock, asynchronous active-high reset
//   ID_rs, ID_rt           source registers of the instruction in ID
//   ID_RegsReadSel         bit0: ID reads rs, bit1: ID reads rt
//   EXE_IsLoad, EXE_Dst    load flag and destination of the instruction in EXE
//   EXE_BranchTaken        branch/jump in EXE redirects the PC
//   EXE_BrchLikelyNT       branch-likely in EXE not taken, annul delay slot
//   MEM_ExcValid           exception or ERET commits in MEM
//   ICache_Busy, DCache_Busy, MDU_Busy   stall requests
//   PC_Wr .. WB_Wr         load enables (combinational)
//   ID_Flush .. WB_Flush   pipeline register clears (combinational)
//   Redirect_Valid         PC takes the exception vector this cycle
//   MDU_Flush              registered one-cycle MDU cancel after a flush
//   Stall_Cnt              saturating count of cycles with EXE_Wr low
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [1:0]  ID_RegsReadSel,
    input  logic        EXE_IsLoad,
    input  logic [4:0]  EXE_Dst,
    input  logic        EXE_BranchTaken,
    input  logic        EXE_BrchLikelyNT,
    input  logic        MEM_ExcValid,
    input  logic        ICache_Busy,
    input  logic        DCache_Busy,
    input  logic        MDU_Busy,
    output logic        PC_Wr,
    output logic        ID_Wr,
    output logic        EXE_Wr,
    output logic        MEM_Wr,
    output logic        WB_Wr,
    output logic        ID_Flush,
    output logic        EXE_Flush,
    output logic        MEM_Flush,
    output logic        WB_Flush,
    output logic        Redirect_Valid,
    output logic        MDU_Flush,
    output logic [31:0] Stall_Cnt
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_EXC_WAIT = 2'd1,
        ST_EXC_POST = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        mdu_flush_r;
    logic [31:0] stall_cnt_r;

    logic        load_use_s;
    logic        exc_pend_s;
    logic        exc_flush_s;
    logic        pc_wr_s, id_wr_s, exe_wr_s, mem_wr_s, wb_wr_s;
    logic        id_flush_s, exe_flush_s, mem_flush_s, wb_flush_s;
    logic        redirect_s;

    // Load-use hazard: a load in EXE whose non-zero destination is read by ID.
    always_comb begin
        load_use_s = EXE_IsLoad && (EXE_Dst != 5'd0) &&
                     ((ID_RegsReadSel[0] && (ID_rs == EXE_Dst)) ||
                      (ID_RegsReadSel[1] && (ID_rt == EXE_Dst)));
    end

    // Priority resolution of all strobes and the next FSM state.
    always_comb begin
        pc_wr_s     = 1'b1;
        id_wr_s     = 1'b1;
        exe_wr_s    = 1'b1;
        mem_wr_s    = 1'b1;
        wb_wr_s     = 1'b1;
        id_flush_s  = 1'b0;
        exe_flush_s = 1'b0;
        mem_flush_s = 1'b0;
        wb_flush_s  = 1'b0;
        redirect_s  = 1'b0;
        exc_flush_s = 1'b0;
        state_nxt_s = ST_NORMAL;

        // EXC_WAIT keeps the exception pending regardless of MEM_ExcValid;
        // EXC_POST treats a fresh MEM_ExcValid exactly like NORMAL does.
        case (state_r)
            ST_EXC_WAIT: exc_pend_s = 1'b1;
            ST_NORMAL:   exc_pend_s = MEM_ExcValid;
            ST_EXC_POST: exc_pend_s = MEM_ExcValid;
            default:     exc_pend_s = MEM_ExcValid;
        endcase

        if (rst) begin
            // Everything frozen and quiet while reset is held.
            pc_wr_s     = 1'b0;
            id_wr_s     = 1'b0;
            exe_wr_s    = 1'b0;
            mem_wr_s    = 1'b0;
            wb_wr_s     = 1'b0;
            state_nxt_s = ST_NORMAL;
        end else if (exc_pend_s && !DCache_Busy) begin
            id_flush_s  = 1'b1;
            exe_flush_s = 1'b1;
            mem_flush_s = 1'b1;
            wb_flush_s  = 1'b1;
            redirect_s  = 1'b1;
            exc_flush_s = 1'b1;
            state_nxt_s = ST_EXC_POST;
        end else if (exc_pend_s) begin
            // Freeze the whole pipe until the outstanding D-miss returns.
            pc_wr_s     = 1'b0;
            id_wr_s     = 1'b0;
            exe_wr_s    = 1'b0;
            mem_wr_s    = 1'b0;
            wb_wr_s     = 1'b0;
            state_nxt_s = ST_EXC_WAIT;
        end else if (DCache_Busy || MDU_Busy) begin
            // Hold PC..MEM; WB still loads, but a bubble so nothing retires twice.
            pc_wr_s     = 1'b0;
            id_wr_s     = 1'b0;
            exe_wr_s    = 1'b0;
            mem_wr_s    = 1'b0;
            wb_flush_s  = 1'b1;
        end else if (load_use_s) begin
            pc_wr_s     = 1'b0;
            id_wr_s     = 1'b0;
            exe_flush_s = 1'b1;
        end else if (EXE_BranchTaken) begin
            // PC loads even on an I-miss: the fetch unit drops the stale miss.
            id_flush_s  = 1'b1;
        end else if (EXE_BrchLikelyNT) begin
            exe_flush_s = 1'b1;
        end else if (ICache_Busy) begin
            pc_wr_s     = 1'b0;
            id_flush_s  = 1'b1;
        end else begin
            redirect_s  = 1'b0;
        end
    end

    // FSM state, delayed MDU cancel and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_NORMAL;
            mdu_flush_r <= 1'b0;
            stall_cnt_r <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            mdu_flush_r <= exc_flush_s;
            if (!exe_wr_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign PC_Wr          = pc_wr_s;
    assign ID_Wr          = id_wr_s;
    assign EXE_Wr         = exe_wr_s;
    assign MEM_Wr         = mem_wr_s;
    assign WB_Wr          = wb_wr_s;
    assign ID_Flush       = id_flush_s;
    assign EXE_Flush      = exe_flush_s;
    assign MEM_Flush      = mem_flush_s;
    assign WB_Flush       = wb_flush_s;
    assign Redirect_Valid = redirect_s;
    assign MDU_Flush      = mdu_flush_r;
    assign Stall_Cnt      = stall_cnt_r;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline stall/flush controller for the five-stage core. It produces the per-stage write-enable (`*_Wr`) and flush (`*_Flush`) strobes consumed by the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It resolves load-use hazards, cache and MDU stalls, branch redirects, branch-likely annulment and MEM-stage exceptions. It holds an exception that arrives during a D-cache miss until the miss completes, and issues a delayed MDU cancel pulse.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous reset, active-high.
- `ID_rs`, `ID_rt` in 5 each: source register numbers of the instruction in ID.
- `ID_RegsReadSel` in 2: bit0 means ID reads rs; bit1 means ID reads rt.
- `EXE_IsLoad` in 1: the instruction in EXE is a load.
- `EXE_Dst` in 5: destination register of the instruction in EXE.
- `EXE_BranchTaken` in 1: the branch or jump in EXE redirects.
- `EXE_BrchLikelyNT` in 1: the branch-likely in EXE is not taken, so its delay slot (in ID) is annulled.
- `MEM_ExcValid` in 1: exception or ERET commits in MEM.
- `ICache_Busy`, `DCache_Busy`, `MDU_Busy` in 1 each: stall requests from the caches and the MDU.
- `PC_Wr`, `ID_Wr`, `EXE_Wr`, `MEM_Wr`, `WB_Wr` out 1 each: load enables for the PC and for each pipeline register.
- `ID_Flush`, `EXE_Flush`, `MEM_Flush`, `WB_Flush` out 1 each: synchronous clear of the named pipeline register.
- `Redirect_Valid` out 1: the PC takes the exception vector this cycle.
- `MDU_Flush` out 1: registered one-cycle MDU cancel.
- `Stall_Cnt` out 32: count of cycles in which `EXE_Wr`=0.

## Operation
- FSM states: NORMAL, EXC_WAIT, EXC_POST.
- Default (no condition below applies): all `*_Wr`=1, all `*_Flush`=0, `Redirect_Valid`=0.
- Conditions are evaluated in priority order; the first match wins.
- P1, exception flush. Applies in NORMAL when `MEM_ExcValid`=1 and `DCache_Busy`=0, or in EXC_WAIT when `DCache_Busy`=0.
  - `ID_Flush`, `EXE_Flush`, `MEM_Flush`, `WB_Flush` = 1.
  - All `*_Wr`=1.
  - `Redirect_Valid`=1.
  - Next state: EXC_POST.
- P2, exception blocked by D-cache. Applies in NORMAL when `MEM_ExcValid`=1 and `DCache_Busy`=1, or in EXC_WAIT when `DCache_Busy`=1.
  - All `*_Wr`=0 and all `*_Flush`=0.
  - Next state: EXC_WAIT.
  - EXC_WAIT ignores every other input.
- P3, back-end stall. Applies when `DCache_Busy`=1 or `MDU_Busy`=1.
  - `PC_Wr`, `ID_Wr`, `EXE_Wr`, `MEM_Wr` = 0.
  - `WB_Wr`=1 and `WB_Flush`=1, so a bubble enters WB.
- P4, load-use hazard. Applies when `EXE_IsLoad`=1, `EXE_Dst`≠0, and (`ID_RegsReadSel[0]` and `ID_rs`==`EXE_Dst`) or (`ID_RegsReadSel[1]` and `ID_rt`==`EXE_Dst`).
  - `PC_Wr`=0, `ID_Wr`=0.
  - `EXE_Flush`=1, so a bubble enters EXE.
- P5, redirect. Applies when `EXE_BranchTaken`=1.
  - `ID_Flush`=1: the wrong-path fetch is squashed and the delay slot proceeds.
  - `PC_Wr`=1 even if `ICache_Busy`=1; the fetch unit cancels its outstanding miss.
- P6, branch-likely not taken. Applies when `EXE_BrchLikelyNT`=1.
  - `EXE_Flush`=1 annuls the delay slot.
  - All `*_Wr`=1.
- P7, fetch stall. Applies when `ICache_Busy`=1.
  - `PC_Wr`=0.
  - `ID_Flush`=1, so a bubble enters ID.
  - Downstream stages advance.
- P4 and P5/P6 cannot co-occur (a load is never a branch). If they do, P4 wins.
- EXC_POST:
  - `MDU_Flush`=1 for exactly this cycle.
  - Datapath outputs follow the NORMAL priority.
  - Next state is NORMAL. If `MEM_ExcValid` is asserted in EXC_POST, it is taken as a new exception per P1/P2.
- `Stall_Cnt` increments by 1 every cycle `EXE_Wr`=0, and saturates at 32'hFFFFFFFF.

## Timing
- All `*_Wr`, `*_Flush` and `Redirect_Valid` outputs are combinational from inputs and state, valid in the same cycle.
- `MDU_Flush` is registered. It asserts in the cycle after the P1 cycle and lasts 1 cycle.
- `Stall_Cnt` is registered. It reflects a stall cycle on the following edge.
- Reset (asynchronous, immediate), held while `rst`=1:
  - state = NORMAL, `MDU_Flush`=0, `Stall_Cnt`=0.
  - All `*_Wr`=0, all `*_Flush`=0, `Redirect_Valid`=0.
- Reset during EXC_WAIT abandons the pending exception; no flush is issued afterwards.
- Exception latency:
  - `MEM_ExcValid` with `DCache_Busy`=0 flushes in the same cycle.
  - With a busy D-cache, the flush occurs in the first cycle `DCache_Busy` is observed low.

## Test plan
- Load-use: `EXE_IsLoad`=1, `EXE_Dst`=5, `ID_rs`=5, `ID_RegsReadSel`=01 → `PC_Wr`=`ID_Wr`=0, `EXE_Flush`=1, `Stall_Cnt` unchanged. Repeat with `EXE_Dst`=0 → no stall.
- MDU stall: `MDU_Busy`=1 for 4 cycles → `PC_Wr`/`ID_Wr`/`EXE_Wr`/`MEM_Wr`=0 and `WB_Flush`=1 each cycle; `Stall_Cnt`=4 afterwards.
- Exception during D-miss: `MEM_ExcValid`=1 with `DCache_Busy`=1 for 3 cycles → 3 cycles of all `*_Wr`=0. On the 4th cycle (`DCache_Busy`=0) all four flushes, `Redirect_Valid`=1; `MDU_Flush`=1 on the 5th cycle only.
- Branch with fetch miss: `EXE_BranchTaken`=1 and `ICache_Busy`=1 → `PC_Wr`=1, `ID_Flush`=1, `EXE_Flush`=0. `EXE_BrchLikelyNT`=1 alone → `EXE_Flush`=1, `ID_Flush`=0.
- Priority: `MEM_ExcValid`=1, `MDU_Busy`=1, load-use hazard all asserted with `DCache_Busy`=0 → P1 flush only, `Redirect_Valid`=1.
- Async reset: assert `rst` mid-clock in EXC_WAIT → outputs go to reset values immediately. Deassert with `DCache_Busy`=0 → NORMAL defaults, no flush, `MDU_Flush`=0.
